// File: rtl/mux_control_forzado_rr_if.sv
// ---------------------------------------------------------------------------
// mux_control_forzado_rr_if
//   Bundles the stream-side signals of mux_control_forzado_rr.
//   master : source/controller side (drives CONTROL, DATA_IN, VALID_IN)
//   slave  : the mux itself (drives READY_IN, OUT, VALID, SEL_OUT, DROP_COUNT)
//   CONTROL    [CTRL_W]          mode/channel code
//   DATA_IN    [CHANNELS*DATA_W] packed channel data, channel i at [i*DATA_W +: DATA_W]
//   VALID_IN   [CHANNELS]        per-channel valid
//   READY_IN   [CHANNELS]        one-hot grant back to the sources
//   OUT        [DATA_W]          registered output word
//   VALID      [1]               OUT carries a freshly transferred word
//   SEL_OUT    [SEL_W]           channel index that produced OUT
//   DROP_COUNT [CNT_W]           saturating count of cycles with unserved requests
// ---------------------------------------------------------------------------
interface mux_control_forzado_rr_if #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 8,
    parameter int CTRL_W   = 4,
    parameter int CNT_W    = 8
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CTRL_W-1:0]          CONTROL;
    logic [CHANNELS*DATA_W-1:0] DATA_IN;
    logic [CHANNELS-1:0]        VALID_IN;
    logic [CHANNELS-1:0]        READY_IN;
    logic [DATA_W-1:0]          OUT;
    logic                       VALID;
    logic [SEL_W-1:0]           SEL_OUT;
    logic [CNT_W-1:0]           DROP_COUNT;

    modport master (
        output CONTROL, DATA_IN, VALID_IN,
        input  READY_IN, OUT, VALID, SEL_OUT, DROP_COUNT
    );

    modport slave (
        input  CONTROL, DATA_IN, VALID_IN,
        output READY_IN, OUT, VALID, SEL_OUT, DROP_COUNT
    );
endinterface

// File: rtl/mux_control_forzado_rr.sv
// ---------------------------------------------------------------------------
// mux_control_forzado_rr
//   Selects one of CHANNELS valid/ready streams onto a registered output.
//   The registered control code either forces one channel, runs a fair
//   round-robin arbiter, or idles the output to IDLE_PATTERN.
//   CLK     : rising-edge clock
//   RESET_L : asynchronous active-low reset
//   bus     : stream signals (see mux_control_forzado_rr_if, slave modport)
// ---------------------------------------------------------------------------
module mux_control_forzado_rr #(
    parameter int                CHANNELS     = 4,
    parameter int                DATA_W       = 8,
    parameter int                CTRL_W       = 4,
    parameter int                CNT_W        = 8,
    parameter logic [DATA_W-1:0] IDLE_PATTERN = '0
) (
    input  logic                    CLK,
    input  logic                    RESET_L,
    mux_control_forzado_rr_if.slave bus
);
    localparam int                SEL_W   = $clog2(CHANNELS);
    localparam logic [CTRL_W-1:0] CH_CODE = CTRL_W'(CHANNELS);
    localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        MODE_FORCED = 2'd0,
        MODE_RR     = 2'd1,
        MODE_IDLE   = 2'd2
    } mode_t;

    logic [CTRL_W-1:0]   ctrl_q;
    logic [SEL_W-1:0]    ptr;
    mode_t               mode;
    logic [CHANNELS-1:0] ready;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    cand;
    logic                found;
    logic                unserved;

    logic [DATA_W-1:0]   out_q;
    logic                valid_q;
    logic [SEL_W-1:0]    sel_q;
    logic [CNT_W-1:0]    drop_q;

    // Mode comes from the registered code only, so a new CONTROL value
    // takes effect one edge after it is sampled.
    always_comb begin
        mode = MODE_IDLE;
        if (ctrl_q < CH_CODE) begin
            mode = MODE_FORCED;
        end else if (ctrl_q == '1) begin
            mode = MODE_RR;
        end
    end

    // Grant selection. found doubles as the transfer strobe since the
    // granted channel is always one whose valid is set.
    always_comb begin
        ready     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        unique case (mode)
            MODE_FORCED: begin
                grant_idx = SEL_W'(ctrl_q);
                found     = bus.VALID_IN[grant_idx];
            end
            MODE_RR: begin
                // Search ptr, ptr+1, ... wrapping modulo CHANNELS; the modulo
                // keeps the wrap correct for non-power-of-two channel counts.
                for (int unsigned k = 0; k < CHANNELS; k++) begin
                    cand = SEL_W'((32'(ptr) + k) % CHANNELS);
                    if (!found && bus.VALID_IN[cand]) begin
                        found     = 1'b1;
                        grant_idx = cand;
                    end
                end
            end
            default: begin
            end
        endcase
        ready[grant_idx] = found;
    end

    assign unserved = |(bus.VALID_IN & ~ready);

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            ctrl_q  <= '1;
            ptr     <= '0;
            out_q   <= IDLE_PATTERN;
            valid_q <= 1'b0;
            sel_q   <= '0;
            drop_q  <= '0;
        end else begin
            ctrl_q  <= bus.CONTROL;
            valid_q <= found;
            if (found) begin
                out_q <= bus.DATA_IN[grant_idx*DATA_W +: DATA_W];
                sel_q <= grant_idx;
            end else if (mode == MODE_IDLE) begin
                out_q <= IDLE_PATTERN;
            end
            if (found && (mode == MODE_RR)) begin
                ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            end
            if (unserved && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign bus.READY_IN   = ready;
    assign bus.OUT        = out_q;
    assign bus.VALID      = valid_q;
    assign bus.SEL_OUT    = sel_q;
    assign bus.DROP_COUNT = drop_q;
endmodule

// File: tb/tb_mux_control_forzado_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_control_forzado_rr
//   Self-checking bench for mux_control_forzado_rr (CHANNELS=4, DATA_W=8,
//   CTRL_W=4, CNT_W=8). Expected output words are queued when stimulus is
//   applied and popped after the edge that should produce them.
// ---------------------------------------------------------------------------
module tb_mux_control_forzado_rr;
    localparam int CH = 4;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int NW = 8;

    logic CLK = 1'b0;
    logic RESET_L = 1'b0;

    mux_control_forzado_rr_if #(.CHANNELS(CH), .DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) bus ();

    mux_control_forzado_rr #(
        .CHANNELS(CH), .DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .IDLE_PATTERN(8'h00)
    ) dut (
        .CLK(CLK),
        .RESET_L(RESET_L),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [1:0] s;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    exp_t got;
    int   total = 0;
    int   bad   = 0;

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET_L = 1'b0;
        @(posedge CLK); #1;
        RESET_L = 1'b1;
    endtask

    task automatic test_reset();
        bus.CONTROL  = 4'hF;
        bus.VALID_IN = 4'b0000;
        RESET_L      = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        total++; if (bus.OUT !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", bus.OUT); end
        total++; if (bus.VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.VALID); end
        total++; if (bus.SEL_OUT !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", bus.SEL_OUT); end
        total++; if (bus.DROP_COUNT !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", bus.DROP_COUNT); end
        total++; if (bus.READY_IN !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.READY_IN); end
        // Reset leaves round-robin mode with ptr=0, so all-valid grants channel 0.
        bus.VALID_IN = 4'b1111; #1;
        total++; if (bus.READY_IN !== 4'b0001) begin bad++; $display("FAIL reset_ready_rr: got %b want 0001", bus.READY_IN); end
        bus.VALID_IN = 4'b0000;
        @(posedge CLK); #1;
        RESET_L = 1'b1;
    endtask

    task automatic test_forced_sweep();
        for (int c = 0; c < 10; c++) begin
            bus.CONTROL  = 4'(c);
            bus.VALID_IN = 4'b1111;
            if (c < 4) sbq.push_back('{v: 1'b1, d: 8'(8'hA0 + c), s: 2'(c)});
            else       sbq.push_back('{v: 1'b0, d: 8'h00, s: 2'd3});
            @(posedge CLK); #1;
            total++;
            if (c < 4) begin
                if (bus.READY_IN !== 4'(1 << c)) begin bad++; $display("FAIL sweep_ready[%0d]: got %b want %b", c, bus.READY_IN, 4'(1 << c)); end
            end else begin
                if (bus.READY_IN !== 4'b0000) begin bad++; $display("FAIL sweep_ready[%0d]: got %b want 0000", c, bus.READY_IN); end
            end
            @(posedge CLK); #1;
            e = sbq.pop_front();
            got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
            total++;
            if (got !== e) begin bad++; $display("FAIL sweep_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", c, got.v, got.d, got.s, e.v, e.d, e.s); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.CONTROL  = 4'hF;
        bus.VALID_IN = 4'b1111;
        for (int i = 0; i < 8; i++) sbq.push_back('{v: 1'b1, d: 8'(8'hA0 + (i % 4)), s: 2'(i % 4)});
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
            total++;
            if (got !== e) begin bad++; $display("FAIL rr_all[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", i, got.v, got.d, got.s, e.v, e.d, e.s); end
        end
        total++; if (bus.DROP_COUNT !== 8'd8) begin bad++; $display("FAIL rr_all_drop: got %0d want 8", bus.DROP_COUNT); end
    endtask

    task automatic test_rr_partial();
        // ptr is 0 after the previous eight grants.
        bus.VALID_IN = 4'b1010; #1;
        total++; if (bus.READY_IN !== 4'b0010) begin bad++; $display("FAIL rr_part_ready: got %b want 0010", bus.READY_IN); end
        sbq.push_back('{v: 1'b1, d: 8'hA1, s: 2'd1});
        sbq.push_back('{v: 1'b1, d: 8'hA3, s: 2'd3});
        sbq.push_back('{v: 1'b1, d: 8'hA1, s: 2'd1});
        sbq.push_back('{v: 1'b1, d: 8'hA3, s: 2'd3});
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
            total++;
            if (got !== e) begin bad++; $display("FAIL rr_part[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", i, got.v, got.d, got.s, e.v, e.d, e.s); end
        end
        bus.VALID_IN = 4'b0000;
        sbq.push_back('{v: 1'b0, d: 8'hA3, s: 2'd3});
        sbq.push_back('{v: 1'b0, d: 8'hA3, s: 2'd3});
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
            total++;
            if (got !== e) begin bad++; $display("FAIL rr_idle[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", i, got.v, got.d, got.s, e.v, e.d, e.s); end
        end
        bus.VALID_IN = 4'b0010;
        sbq.push_back('{v: 1'b1, d: 8'hA1, s: 2'd1});
        @(posedge CLK); #1;
        e = sbq.pop_front();
        got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
        total++;
        if (got !== e) begin bad++; $display("FAIL rr_ch1: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", got.v, got.d, got.s, e.v, e.d, e.s); end
        // Grant to channel 1 moves ptr to 2; all-valid must then pick channel 2.
        bus.VALID_IN = 4'b1111;
        sbq.push_back('{v: 1'b1, d: 8'hA2, s: 2'd2});
        @(posedge CLK); #1;
        e = sbq.pop_front();
        got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
        total++;
        if (got !== e) begin bad++; $display("FAIL rr_ptr: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", got.v, got.d, got.s, e.v, e.d, e.s); end
    endtask

    task automatic test_saturation();
        do_reset();
        bus.CONTROL  = 4'd2;
        bus.VALID_IN = 4'b0000;
        @(posedge CLK); #1;
        bus.VALID_IN = 4'b0001; #1;
        total++; if (bus.READY_IN !== 4'b0000) begin bad++; $display("FAIL sat_ready: got %b want 0000", bus.READY_IN); end
        for (int i = 1; i <= 300; i++) begin
            sbq.push_back('{v: 1'b0, d: 8'h00, s: 2'd0});
            @(posedge CLK); #1;
            e = sbq.pop_front();
            got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
            total++;
            if (got !== e) begin bad++; $display("FAIL sat_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", i, got.v, got.d, got.s, e.v, e.d, e.s); end
            if (i == 254 || i == 255 || i == 300) begin
                total++;
                if (bus.DROP_COUNT !== 8'((i > 255) ? 255 : i)) begin
                    bad++; $display("FAIL sat_drop[%0d]: got %0d want %0d", i, bus.DROP_COUNT, (i > 255) ? 255 : i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.CONTROL  = 4'hF;
        bus.VALID_IN = 4'b1111;
        sbq.push_back('{v: 1'b1, d: 8'hA0, s: 2'd0});
        sbq.push_back('{v: 1'b1, d: 8'hA1, s: 2'd1});
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            e = sbq.pop_front();
            got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
            total++;
            if (got !== e) begin bad++; $display("FAIL mid_pre[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", i, got.v, got.d, got.s, e.v, e.d, e.s); end
        end
        // ptr is now 2; pulse reset between edges.
        #1;
        RESET_L = 1'b0; #1;
        total++; if (bus.VALID !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", bus.VALID); end
        total++; if (bus.OUT !== 8'h00) begin bad++; $display("FAIL mid_out: got %h want 00", bus.OUT); end
        total++; if (bus.SEL_OUT !== 2'd0) begin bad++; $display("FAIL mid_sel: got %0d want 0", bus.SEL_OUT); end
        total++; if (bus.DROP_COUNT !== 8'd0) begin bad++; $display("FAIL mid_drop: got %0d want 0", bus.DROP_COUNT); end
        total++; if (bus.READY_IN !== 4'b0001) begin bad++; $display("FAIL mid_ready: got %b want 0001", bus.READY_IN); end
        #1;
        RESET_L = 1'b1;
        sbq.push_back('{v: 1'b1, d: 8'hA0, s: 2'd0});
        @(posedge CLK); #1;
        e = sbq.pop_front();
        got = '{v: bus.VALID, d: bus.OUT, s: bus.SEL_OUT};
        total++;
        if (got !== e) begin bad++; $display("FAIL mid_post: got v=%b d=%h s=%0d want v=%b d=%h s=%0d", got.v, got.d, got.s, e.v, e.d, e.s); end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) bus.DATA_IN[i*DW +: DW] = 8'(8'hA0 + i);
        test_reset();
        test_forced_sweep();
        test_back_to_back();
        test_rr_partial();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_control_forzado_rr.md
# mux_control_forzado_rr

Parametrised successor of the forced-control mux: selects one of CHANNELS valid/ready input streams onto a single registered output. The registered CONTROL code either forces a fixed channel, runs a fair round-robin arbiter over all channels, or idles the output to a constant pattern. It sits between the per-lane sources and the downstream serializer, and adds backpressure (per-channel ready) and a saturating count of unserved requests.

## Interface
- CHANNELS, 4, number of input channels; 2 ≤ CHANNELS ≤ 2^CTRL_W − 1
- DATA_W, 8, data width per channel
- CTRL_W, 4, width of CONTROL
- CNT_W, 8, width of DROP_COUNT
- IDLE_PATTERN, {DATA_W{1'b0}}, value driven on OUT in idle mode and after reset
- SEL_W, $clog2(CHANNELS), localparam, width of SEL_OUT
- CLK  in  1  clock, all state updates on rising edge
- RESET_L  in  1  asynchronous, active-low reset
- CONTROL  in  CTRL_W  mode/channel code, registered internally
- DATA_IN  in  CHANNELS*DATA_W  packed data; channel i at [i*DATA_W +: DATA_W]
- VALID_IN  in  CHANNELS  per-channel valid
- READY_IN  out  CHANNELS  one-hot grant; combinational from ctrl_q, ptr, VALID_IN
- OUT  out  DATA_W  registered output data
- VALID  out  1  registered; 1 when OUT carries a word transferred on the last edge
- SEL_OUT  out  SEL_W  registered index of the channel that produced OUT
- DROP_COUNT  out  CNT_W  saturating count of cycles with unserved requests

## Operation
- ctrl_q <= CONTROL every edge. Mode decode from ctrl_q only:
  - ctrl_q < CHANNELS: forced mode, candidate = ctrl_q
  - ctrl_q == all-ones: round-robin mode
  - otherwise (CHANNELS … 2^CTRL_W − 2): idle mode
- Grant (READY_IN):
  - Forced: READY_IN[ctrl_q] = VALID_IN[ctrl_q]; all others 0.
  - Round-robin: first i with VALID_IN[i]=1 searching ptr, ptr+1, …, wrapping mod CHANNELS; READY_IN one-hot at i; all zero if no valid.
  - Idle: READY_IN all zero.
- Transfer = READY_IN[i] & VALID_IN[i] at a rising edge. On transfer: OUT <= DATA_IN[i], SEL_OUT <= i, VALID <= 1.
- No transfer, forced/RR mode: VALID <= 0; OUT, SEL_OUT hold.
- Idle mode: VALID <= 0, OUT <= IDLE_PATTERN, SEL_OUT holds.
- ptr (SEL_W bits): on RR transfer from i, ptr <= (i+1) mod CHANNELS (wrap at CHANNELS−1 → 0, also for non-power-of-2 CHANNELS). Unchanged in forced/idle mode and on no-transfer cycles.
- DROP_COUNT += 1 on each edge where (VALID_IN & ~READY_IN) != 0; saturates at 2^CNT_W − 1, never wraps.

## Timing
- Reset (RESET_L=0, async, immediate): OUT=IDLE_PATTERN, VALID=0, SEL_OUT=0, DROP_COUNT=0, ptr=0, ctrl_q=all-ones (round-robin). READY_IN follows from those values.
- CONTROL latency: CONTROL sampled at edge k is in effect for READY_IN during cycle k..k+1; first word under new mode appears on OUT after edge k+1.
- Data latency: 1 cycle; word transferred at edge k is on OUT/VALID/SEL_OUT after edge k, held one cycle unless replaced.
- Throughput: one word per cycle; no bubbles between back-to-back transfers.
- READY_IN may toggle combinationally with VALID_IN; sources must not gate VALID_IN on READY_IN.
- Mode change mid-stream: no word lost or duplicated; the word sampled on the switching edge follows the old mode.
- Reset deasserted mid-operation: first transfer possible on the first edge with RESET_L=1.

## Test plan
- CHANNELS=4, DATA_W=8, CTRL_W=4. Reset held 2 cycles → OUT=8'h00, VALID=0, SEL_OUT=0, DROP_COUNT=0, READY_IN=4'b0000 with VALID_IN=0.
- CONTROL swept 0…9 every 2 cycles, all VALID_IN=1, DATA_IN[i]=8'hA0+i → codes 0–3 give OUT=8'hA0…8'hA3 with SEL_OUT=code one cycle after sampling; codes 4–9 give VALID=0, OUT=8'h00.
- CONTROL=4'hF, all VALID_IN=1 for 8 cycles → SEL_OUT sequence 0,1,2,3,0,1,2,3, VALID=1 every cycle, DROP_COUNT=8.
- RR with VALID_IN=4'b1010 → SEL_OUT alternates 1,3,1,3; then VALID_IN=0 → VALID=0, ptr held; re-enable channel 1 only → SEL_OUT=1.
- Forced CONTROL=2 with VALID_IN[2]=0, VALID_IN[0]=1 for 300 cycles, CNT_W=8 → VALID=0 throughout, DROP_COUNT saturates at 255.
- RESET_L pulsed low mid-RR stream (ptr=2) → outputs reset immediately, next grant with all valid is channel 0.
